ex_muldiv_ctrl: RTL and testbench

Sequencer for the iterative RV64M multiply/divide unit attached to the execute stage. While the execute stage holds a multi-cycle M-extension op, it hands the operands to this block and keeps its `ok` low. The block runs a shift-add multiply or a restoring shift-subtract divide one bit per cycle and resolves the RISC-V special cases without iterating. It then presents the result until execute accepts it. A flush from the pipeline aborts any operation in progress.

---
 rtl/ex_muldiv_ctrl_if.sv | 36 +++
 rtl/ex_muldiv_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_ex_muldiv_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_ctrl_if.sv
// ex_muldiv_ctrl_if
//   Request/result bundle between the execute stage and the iterative
//   RV64M multiply/divide sequencer.
//   master : execute stage (drives requests, flush and result_ack)
//   slave  : ex_muldiv_ctrl (drives ready/busy/done/result)
//   Signals:
//     req_valid/req_ready  request handshake
//     req_op               4-bit M-op code
//     req_op1/req_op2      forwarded rs1/rs2 values
//     flush                abort the current operation
//     busy/done            iteration in progress / result valid
//     result/result_ack    final rd value and its consume strobe
interface ex_muldiv_ctrl_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic [3:0]      req_op;
  logic [XLEN-1:0] req_op1;
  logic [XLEN-1:0] req_op2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            result_ack;

  modport master (
    output req_valid, req_op, req_op1, req_op2, flush, result_ack,
    input  req_ready, busy, done, result
  );

  modport slave (
    input  req_valid, req_op, req_op1, req_op2, flush, result_ack,
    output req_ready, busy, done, result
  );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl
//   Sequencer for the iterative RV64M multiply/divide unit. Accepts one
//   M-op from execute, runs a shift-add multiply or restoring divide one
//   bit per cycle, resolves divide-by-zero / signed overflow / illegal ops
//   without iterating, then holds the result until execute acknowledges.
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      ex_muldiv_ctrl_if.slave (request, flush, result handshake)
module ex_muldiv_ctrl #(
  parameter int XLEN = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  ex_muldiv_ctrl_if.slave  bus
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t          state;
  logic [6:0]      cnt;
  logic            op_mul;
  logic            op_rem;
  logic            op_w;
  logic            neg_q;
  logic            neg_r;
  // Multiply: work_a = accumulator, work_b = multiplicand, work_c = multiplier.
  // Divide:   work_a = partial remainder, work_b = dividend/quotient shift
  //           register, work_c = divisor magnitude.
  logic [XLEN-1:0] work_a;
  logic [XLEN-1:0] work_b;
  logic [XLEN-1:0] work_c;
  logic [XLEN-1:0] result_q;

  function automatic logic [XLEN-1:0] f_sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] f_cond_neg(input logic [XLEN-1:0] v,
                                                 input logic            n);
    return n ? (~v + 1'b1) : v;
  endfunction

  // Request decode (evaluated against the live request inputs).
  logic                   dec_legal;
  logic                   dec_mul;
  logic                   dec_w;
  logic                   dec_sgn;
  logic                   dec_rem;
  logic [31:0]            lo_a;
  logic [31:0]            lo_b;
  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic                   a_neg;
  logic                   b_neg;
  logic [XLEN-1:0]        a_mag;
  logic [XLEN-1:0]        b_mag;
  logic [XLEN-1:0]        dvd_ext;
  logic                   div_zero;
  logic                   div_ovf;
  logic                   dec_special;
  logic [XLEN-1:0]        spec_res;

  always_comb begin
    dec_legal = (bus.req_op <= 4'd9);
    dec_mul   = (bus.req_op == 4'd0) || (bus.req_op == 4'd1);
    dec_w     = bus.req_op inside {4'd1, 4'd6, 4'd7, 4'd8, 4'd9};
    dec_sgn   = bus.req_op inside {4'd2, 4'd4, 4'd6, 4'd8};
    dec_rem   = bus.req_op inside {4'd4, 4'd5, 4'd8, 4'd9};
    lo_a      = bus.req_op1[31:0];
    lo_b      = bus.req_op2[31:0];
    if (dec_w) begin
      a_s = dec_sgn ? $signed(f_sext32(lo_a)) : $signed({{(XLEN-32){1'b0}}, lo_a});
      b_s = dec_sgn ? $signed(f_sext32(lo_b)) : $signed({{(XLEN-32){1'b0}}, lo_b});
    end else begin
      a_s = $signed(bus.req_op1);
      b_s = $signed(bus.req_op2);
    end
    a_neg    = dec_sgn & a_s[XLEN-1];
    b_neg    = dec_sgn & b_s[XLEN-1];
    a_mag    = f_cond_neg(a_s, a_neg);
    b_mag    = f_cond_neg(b_s, b_neg);
    // Dividend as it appears in rd: W results are always sign-extended
    // from bit 31, even for the unsigned W variants.
    dvd_ext  = dec_w ? f_sext32(lo_a) : bus.req_op1;
    div_zero = dec_legal & ~dec_mul & (b_s == '0);
    div_ovf  = dec_sgn & (dec_w ? ((lo_a == 32'h8000_0000) && (lo_b == 32'hFFFF_FFFF))
                                : ((bus.req_op1 == MOST_NEG) && (bus.req_op2 == '1)));
    dec_special = ~dec_legal | div_zero | div_ovf;
    if (!dec_legal) begin
      spec_res = '0;
    end else if (dec_rem) begin
      spec_res = div_zero ? dvd_ext : '0;
    end else begin
      spec_res = div_zero ? '1 : dvd_ext;
    end
  end

  // One iteration step plus the final formatting used on the last step.
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic [XLEN-1:0] nx_a;
  logic [XLEN-1:0] nx_b;
  logic [XLEN-1:0] nx_c;
  logic [XLEN-1:0] fin_raw;
  logic [XLEN-1:0] fin_res;

  always_comb begin
    div_shift = {work_a, work_b[XLEN-1]};
    div_diff  = div_shift - {1'b0, work_c};
    if (op_mul) begin
      nx_a = work_c[0] ? (work_a + work_b) : work_a;
      nx_b = work_b << 1;
      nx_c = work_c >> 1;
    end else begin
      // A borrow out of the trial subtraction means restore.
      nx_a = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
      nx_b = {work_b[XLEN-2:0], ~div_diff[XLEN]};
      nx_c = work_c;
    end
    if (op_mul) begin
      fin_raw = nx_a;
    end else if (op_rem) begin
      fin_raw = f_cond_neg(nx_a, neg_r);
    end else begin
      fin_raw = f_cond_neg(nx_b, neg_q);
    end
    fin_res = op_w ? f_sext32(fin_raw[31:0]) : fin_raw;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_mul   <= 1'b0;
      op_rem   <= 1'b0;
      op_w     <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      work_a   <= '0;
      work_b   <= '0;
      work_c   <= '0;
      result_q <= '0;
    end else if (bus.flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_mul <= dec_mul;
            op_rem <= dec_rem;
            op_w   <= dec_w;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            if (dec_special) begin
              result_q <= spec_res;
              state    <= S_DONE;
            end else begin
              cnt    <= dec_w ? 7'd32 : 7'd64;
              work_a <= '0;
              if (dec_mul) begin
                work_b <= bus.req_op1;
                work_c <= bus.req_op2;
              end else begin
                // W divides start with the 32-bit magnitude in the top
                // half so 32 shifts leave the quotient in bits [31:0].
                work_b <= dec_w ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
                work_c <= b_mag;
              end
              state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          work_a <= nx_a;
          work_b <= nx_b;
          work_c <= nx_c;
          cnt    <= cnt - 7'd1;
          if (cnt == 7'd1) begin
            result_q <= fin_res;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.result_ack) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.busy      = (state == S_BUSY);
  assign bus.done      = (state == S_DONE);
  assign bus.result    = result_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
module tb_ex_muldiv_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ex_muldiv_ctrl_if #(.XLEN(64)) bus ();

  ex_muldiv_ctrl #(.XLEN(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  // Architectural RV64M result, straight from the ISA rules.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] wa, wb;
    logic [31:0] ua, ub, r;
    sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
    case (op)
      4'd0: return a * b;
      4'd1: begin r = ua * ub; return {{32{r[31]}}, r}; end
      4'd2: begin
        if (b == 0) return '1;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
        return sa / sb;
      end
      4'd3: return (b == 0) ? '1 : a / b;
      4'd4: begin
        if (b == 0) return a;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return 64'd0;
        return sa % sb;
      end
      4'd5: return (b == 0) ? a : a % b;
      4'd6: begin
        if (wb == 0) return '1;
        if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r = ua;
        else r = wa / wb;
        return {{32{r[31]}}, r};
      end
      4'd7: begin
        if (ub == 0) return '1;
        r = ua / ub; return {{32{r[31]}}, r};
      end
      4'd8: begin
        if (wb == 0) r = ua;
        else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r = 0;
        else r = wa % wb;
        return {{32{r[31]}}, r};
      end
      4'd9: begin
        r = (ub == 0) ? ua : ua % ub; return {{32{r[31]}}, r};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Cycles from acceptance to the first done sample.
  function automatic int exp_lat(input logic [3:0] op, input logic [63:0] a,
                                 input logic [63:0] b);
    bit w, sgn, zero, ovf;
    if (op > 4'd9) return 1;
    w = (op == 4'd1) || (op >= 4'd6);
    if (op <= 4'd1) return w ? 33 : 65;
    sgn  = (op == 4'd2) || (op == 4'd4) || (op == 4'd6) || (op == 4'd8);
    zero = w ? (b[31:0] == 0) : (b == 0);
    ovf  = sgn && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                     : (a == 64'h8000_0000_0000_0000 && b == '1));
    if (zero || ovf) return 1;
    return w ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h0000_0000_8000_0000;
      5: return 64'h0000_0000_FFFF_FFFF;
      6: return {32'h0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Issue one request (caller is 1 time unit after a rising edge with the
  // block idle) and wait, bounded, for done.
  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input bit scramble, output logic [63:0] res, output int lat,
                        output int nbusy);
    bus.req_op = op; bus.req_op1 = a; bus.req_op2 = b; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (scramble) begin
      bus.req_op1 = {$urandom, $urandom};
      bus.req_op2 = {$urandom, $urandom};
      bus.req_op  = 4'($urandom_range(0, 15));
    end
    lat = 0; nbusy = 0; res = 'x;
    for (int k = 1; k <= 200; k++) begin
      if (bus.busy === 1'b1) nbusy++;
      if (bus.done === 1'b1) begin
        lat = k; res = bus.result;
        break;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (lat == 0) begin
      n_fail++;
      $display("FAIL run_op_timeout op=%0d got=no done required=done within 200", op);
    end
  endtask

  task automatic ack();
    bus.result_ack = 1'b1;
    @(posedge clk); #1;
    bus.result_ack = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = 0; bus.req_op = 0; bus.req_op1 = 0; bus.req_op2 = 0;
    bus.flush = 0; bus.result_ack = 0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.req_ready, bus.busy, bus.done} !== 3'b100) begin
      n_fail++; $display("FAIL reset_ctrl got=%b required=100", {bus.req_ready, bus.busy, bus.done});
    end
    n_checks++;
    if (bus.result !== 64'd0) begin
      n_fail++; $display("FAIL reset_result got=%h required=0", bus.result);
    end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    vec_t tbl[$];
    logic [63:0] res;
    int lat, nb;
    tbl.push_back('{4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65});
    tbl.push_back('{4'd2, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 65});
    tbl.push_back('{4'd4, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 65});
    tbl.push_back('{4'd5, 64'd20, 64'd6, 64'd2, 65});
    tbl.push_back('{4'd3, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1});
    tbl.push_back('{4'd4, 64'h1234, 64'd0, 64'h1234, 1});
    tbl.push_back('{4'd7, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1});
    tbl.push_back('{4'd2, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1});
    tbl.push_back('{4'd4, 64'h8000_0000_0000_0000, '1, 64'd0, 1});
    tbl.push_back('{4'd6, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1});
    tbl.push_back('{4'd6, 64'hABCD_0000_8000_0000, 64'd2, 64'hFFFF_FFFF_C000_0000, 33});
    tbl.push_back('{4'd1, 64'h1_0001_0000, 64'h1_0000, 64'd0, 33});
    tbl.push_back('{4'd9, 64'h8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 1});
    tbl.push_back('{4'd12, 64'd5, 64'd6, 64'd0, 1});
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b1, res, lat, nb);
      n_checks++;
      if (res !== tbl[i].exp) begin
        n_fail++; $display("FAIL dir%0d_result op=%0d got=%h required=%h", i, tbl[i].op, res, tbl[i].exp);
      end
      n_checks++;
      if (lat != tbl[i].lat) begin
        n_fail++; $display("FAIL dir%0d_latency got=%0d required=%0d", i, lat, tbl[i].lat);
      end
      n_checks++;
      if (nb != tbl[i].lat - 1) begin
        n_fail++; $display("FAIL dir%0d_busy_cycles got=%0d required=%0d", i, nb, tbl[i].lat - 1);
      end
      ack();
      n_checks++;
      if ({bus.req_ready, bus.busy, bus.done} !== 3'b100) begin
        n_fail++; $display("FAIL dir%0d_idle_after_ack got=%b required=100", i, {bus.req_ready, bus.busy, bus.done});
      end
    end
  endtask

  task automatic test_flush();
    logic [63:0] res;
    int lat, nb, seen_done;
    bus.req_op = 4'd2; bus.req_op1 = 64'd1000; bus.req_op2 = 64'd7; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      n_checks++;
      if (bus.busy !== 1'b1) begin
        n_fail++; $display("FAIL flush_busy_k%0d got=%b required=1", k, bus.busy);
      end
      if (k < 10) begin
        @(posedge clk); #1;
      end
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n_checks++;
    if ({bus.req_ready, bus.busy, bus.done} !== 3'b100) begin
      n_fail++; $display("FAIL flush_idle got=%b required=100", {bus.req_ready, bus.busy, bus.done});
    end
    seen_done = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen_done++;
    end
    n_checks++;
    if (seen_done != 0) begin
      n_fail++; $display("FAIL flush_no_done got=%0d active cycles required=0", seen_done);
    end
    // Request together with flush is dropped.
    bus.req_op = 4'd3; bus.req_op1 = 64'd9; bus.req_op2 = 64'd3;
    bus.req_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.flush = 1'b0;
    n_checks++;
    if ({bus.req_ready, bus.busy, bus.done} !== 3'b100) begin
      n_fail++; $display("FAIL flush_req_ignored got=%b required=100", {bus.req_ready, bus.busy, bus.done});
    end
    run_op(4'd3, 64'd9, 64'd3, 1'b0, res, lat, nb);
    n_checks++;
    if (res !== 64'd3 || lat != 65) begin
      n_fail++; $display("FAIL flush_next_divu got=%h lat %0d required=3 lat 65", res, lat);
    end
    ack();
  endtask

  task automatic test_ack_hold();
    logic [63:0] res, a, b, e;
    int lat, nb, bad;
    a = {$urandom, $urandom}; b = {32'h0, $urandom} | 64'd1;
    e = model(4'd3, a, b);
    run_op(4'd3, a, b, 1'b1, res, lat, nb);
    n_checks++;
    if (res !== e) begin
      n_fail++; $display("FAIL hold_result got=%h required=%h", res, e);
    end
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b1 || bus.result !== e || bus.req_ready !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL hold_stable got=%0d unstable cycles required=0", bad);
    end
    ack();
  endtask

  task automatic test_async_reset();
    bus.req_op = 4'd0; bus.req_op1 = 64'd123; bus.req_op2 = 64'd456; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre_busy got=%b required=1", bus.busy);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.req_ready, bus.busy, bus.done} !== 3'b100 || bus.result !== 64'd0) begin
      n_fail++; $display("FAIL areset_outputs got=%b/%h required=100/0",
                         {bus.req_ready, bus.busy, bus.done}, bus.result);
    end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [63:0] res, a, b, e;
    logic [3:0] op;
    int lat, nb, el;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 11));
      a = pick(); b = pick();
      e = model(op, a, b);
      el = exp_lat(op, a, b);
      n_checks++;
      if (bus.req_ready !== 1'b1) begin
        n_fail++; $display("FAIL rnd%0d_ready got=%b required=1", i, bus.req_ready);
      end
      run_op(op, a, b, 1'b1, res, lat, nb);
      n_checks++;
      if (res !== e) begin
        n_fail++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h required=%h", i, op, a, b, res, e);
      end
      n_checks++;
      if (lat != el || nb != el - 1) begin
        n_fail++; $display("FAIL rnd%0d_timing op=%0d got=lat %0d busy %0d required=lat %0d busy %0d",
                           i, op, lat, nb, el, el - 1);
      end
      ack();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_ack_hold();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
